// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: configurable word/parity/stop format, 3-sample mid-bit
// majority vote, false-start rejection, error flags and a valid/ready output port.
module uart_rx_ext #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [2:0]           dbg_state_o
);

    localparam int BAUD_CNT = CLK_FREQ / BAUD;
    localparam int TW       = $clog2(BAUD_CNT);
    localparam int H        = BAUD_CNT / 2;

    localparam logic [TW-1:0] TICK_S0   = TW'(H - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(H);
    localparam logic [TW-1:0] TICK_DEC  = TW'(H + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_CNT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    // Encoding is visible on dbg_state_o; IDLE is 0.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   armed_q, armed_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   valid_q, valid_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_out_q, ferr_out_d;
    logic                   overrun_q, overrun_d;

    logic maj, at_dec, at_end, exp_par, final_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= 2'b11;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            armed_q    <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            armed_q    <= armed_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
        at_dec     = (tick_q == TICK_DEC);
        at_end     = (tick_q == TICK_LAST);
        exp_par    = (PARITY == 2) ? ~(^shift_q) : ^shift_q;
        final_ferr = ferr_q | ~maj;

        state_d    = state_q;
        tick_d     = at_end ? '0 : tick_q + TW'(1);
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        armed_d    = armed_q | rx_s_q;
        data_out_d = data_out_q;
        valid_d    = valid_q & ~ready;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = 1'b0;

        if (tick_q == TICK_S0) samp_d[0] = rx_s_q;
        if (tick_q == TICK_S1) samp_d[1] = rx_s_q;

        case (state_q)
            IDLE: begin
                tick_d    = '0;
                bit_cnt_d = '0;
                // The detect cycle itself is tick 0 of the start bit.
                if (!rx_s_q && armed_q) begin
                    state_d = START;
                    tick_d  = TW'(1);
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (at_dec && maj) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end else if (at_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_dec) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (at_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PAR: begin
                if (at_dec) perr_d = maj ^ exp_par;
                if (at_end) state_d = STOP;
            end
            STOP: begin
                if (at_dec) begin
                    if (!maj) ferr_d = 1'b1;
                    // Final stop bit: finish at mid-bit to leave half a bit of resync margin.
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = IDLE;
                        tick_d    = '0;
                        bit_cnt_d = '0;
                        if (final_ferr) armed_d = 1'b0;
                        if (!valid_q || ready) begin
                            data_out_d = shift_q;
                            perr_out_d = perr_q;
                            ferr_out_d = final_ferr;
                            valid_d    = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else if (at_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase
    end

    assign data_out    = data_out_q;
    assign valid       = valid_q;
    assign parity_err  = perr_out_q;
    assign frame_err   = ferr_out_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: an 8N1 instance (a) and an 8E1 instance (b) driven bit-serially.
module tb_uart_rx_ext;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BC       = 16;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1, ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_out_a, data_out_b;
  logic       valid_a, valid_b, parity_err_a, parity_err_b;
  logic       frame_err_a, frame_err_b, overrun_a, overrun_b;
  logic [2:0] state_a, state_b;

  logic [9:0] exp_a_q[$], exp_b_q[$];
  logic [9:0] cap_a[64], cap_b[64];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  int vcyc_a = 0, ovr_a = 0, ovr_b = 0;
  int total = 0, bad = 0;

  uart_rx_ext #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .data_out(data_out_a), .valid(valid_a), .ready(ready_a),
    .parity_err(parity_err_a), .frame_err(frame_err_a), .overrun(overrun_a), .dbg_state_o(state_a));

  uart_rx_ext #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .data_out(data_out_b), .valid(valid_b), .ready(ready_b),
    .parity_err(parity_err_b), .frame_err(frame_err_b), .overrun(overrun_b), .dbg_state_o(state_b));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // capture every accepted word as {parity_err, frame_err, data}
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      cap_a[wr_a[5:0]] <= {parity_err_a, frame_err_a, data_out_a};
      wr_a <= wr_a + 1;
    end
    if (valid_b && ready_b) begin
      cap_b[wr_b[5:0]] <= {parity_err_b, frame_err_b, data_out_b};
      wr_b <= wr_b + 1;
    end
    if (valid_a) vcyc_a <= vcyc_a + 1;
    if (overrun_a) ovr_a <= ovr_a + 1;
    if (overrun_b) ovr_b <= ovr_b + 1;
  end

  // driver: one frame, BC clocks per bit; spike_at inverts the line for one clock
  task automatic drive_frame(input int sel, input logic [7:0] d, input logic has_par,
                             input logic par_bit, input logic stop_bit, input int spike_at);
    int nb;
    logic v;
    nb = has_par ? 11 : 10;
    for (int j = 0; j < nb; j++) begin
      if (j == 0) v = 1'b0;
      else if (j <= 8) v = d[j-1];
      else if (has_par && j == 9) v = par_bit;
      else v = stop_bit;
      for (int t = 0; t < BC; t++) begin
        @(negedge clk);
        if (sel == 0) rx_a = ((j * BC + t) == spike_at) ? ~v : v;
        else rx_b = ((j * BC + t) == spike_at) ? ~v : v;
      end
    end
    @(negedge clk);
    if (sel == 0) rx_a = 1'b1;
    else rx_b = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    total += 6;
    if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    if (data_out_a !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out_a); end
    if (parity_err_a !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", parity_err_a); end
    if (frame_err_a !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err_a); end
    if (overrun_a !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun_a); end
    if (state_a !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_a); end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_basic;
    logic [9:0] exp, got;
    int lat, vc0;
    lat = 0;
    vc0 = vcyc_a;
    exp_a_q.push_back({2'b00, 8'hA5});
    fork
      drive_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
      begin
        @(negedge clk);
        while (!valid_a && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    idle(4);
    total++;
    if (lat != 156) begin bad++; $display("FAIL basic_latency: got %0d clks want 156", lat); end
    total++;
    if (vcyc_a - vc0 != 1) begin bad++; $display("FAIL basic_valid_len: got %0d cycles want 1", vcyc_a - vc0); end
    while (exp_a_q.size() > 0) begin
      exp = exp_a_q.pop_front();
      total++;
      if (rd_a >= wr_a) begin bad++; $display("FAIL basic_frame: got none want %h", exp); end
      else begin
        got = cap_a[rd_a[5:0]];
        rd_a++;
        if (got !== exp) begin bad++; $display("FAIL basic_frame: got %h want %h", got, exp); end
      end
    end
    total++;
    if (wr_a != rd_a) begin bad++; $display("FAIL basic_extra: got %0d extra want 0", wr_a - rd_a); rd_a = wr_a; end
  endtask

  task automatic test_parity;
    logic [9:0] exp, got;
    exp_b_q.push_back({2'b10, 8'h03});
    drive_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, -1);
    exp_b_q.push_back({2'b00, 8'h07});
    drive_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
    idle(4);
    while (exp_b_q.size() > 0) begin
      exp = exp_b_q.pop_front();
      total++;
      if (rd_b >= wr_b) begin bad++; $display("FAIL parity_frame: got none want %h", exp); end
      else begin
        got = cap_b[rd_b[5:0]];
        rd_b++;
        if (got !== exp) begin bad++; $display("FAIL parity_frame: got %h want %h", got, exp); end
      end
    end
    total++;
    if (wr_b != rd_b) begin bad++; $display("FAIL parity_extra: got %0d extra want 0", wr_b - rd_b); rd_b = wr_b; end
  endtask

  task automatic test_frame_err;
    logic [9:0] exp, got;
    exp_a_q.push_back({2'b01, 8'hC3});
    drive_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0, -1);
    rx_a = 1'b0;
    idle(40);
    rx_a = 1'b1;
    idle(20);
    while (exp_a_q.size() > 0) begin
      exp = exp_a_q.pop_front();
      total++;
      if (rd_a >= wr_a) begin bad++; $display("FAIL ferr_frame: got none want %h", exp); end
      else begin
        got = cap_a[rd_a[5:0]];
        rd_a++;
        if (got !== exp) begin bad++; $display("FAIL ferr_frame: got %h want %h", got, exp); end
      end
    end
    total++;
    if (wr_a != rd_a) begin bad++; $display("FAIL ferr_break_spurious: got %0d extra want 0", wr_a - rd_a); rd_a = wr_a; end
    exp_a_q.push_back({2'b00, 8'h5A});
    drive_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    while (exp_a_q.size() > 0) begin
      exp = exp_a_q.pop_front();
      total++;
      if (rd_a >= wr_a) begin bad++; $display("FAIL ferr_recover: got none want %h", exp); end
      else begin
        got = cap_a[rd_a[5:0]];
        rd_a++;
        if (got !== exp) begin bad++; $display("FAIL ferr_recover: got %h want %h", got, exp); end
      end
    end
  endtask

  task automatic test_glitch;
    logic [9:0] exp, got;
    @(negedge clk);
    rx_a = 1'b0;
    idle(4);
    rx_a = 1'b1;
    idle(40);
    total++;
    if (state_a !== 3'd0) begin bad++; $display("FAIL glitch_state: got %0d want 0", state_a); end
    total++;
    if (wr_a != rd_a) begin bad++; $display("FAIL glitch_spurious: got %0d frames want 0", wr_a - rd_a); rd_a = wr_a; end
    exp_a_q.push_back({2'b00, 8'h3C});
    drive_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    while (exp_a_q.size() > 0) begin
      exp = exp_a_q.pop_front();
      total++;
      if (rd_a >= wr_a) begin bad++; $display("FAIL glitch_after: got none want %h", exp); end
      else begin
        got = cap_a[rd_a[5:0]];
        rd_a++;
        if (got !== exp) begin bad++; $display("FAIL glitch_after: got %h want %h", got, exp); end
      end
    end
  endtask

  task automatic test_spike;
    logic [9:0] exp, got;
    // data bit 2 is frame bit 3; tick H of it is clock 3*BC + BC/2
    exp_a_q.push_back({2'b00, 8'h00});
    drive_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 3 * BC + BC / 2);
    idle(4);
    while (exp_a_q.size() > 0) begin
      exp = exp_a_q.pop_front();
      total++;
      if (rd_a >= wr_a) begin bad++; $display("FAIL spike_frame: got none want %h", exp); end
      else begin
        got = cap_a[rd_a[5:0]];
        rd_a++;
        if (got !== exp) begin bad++; $display("FAIL spike_frame: got %h want %h", got, exp); end
      end
    end
    total++;
    if (wr_a != rd_a) begin bad++; $display("FAIL spike_extra: got %0d extra want 0", wr_a - rd_a); rd_a = wr_a; end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp, got;
    logic [7:0] d;
    logic flip;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_a_q.push_back({2'b00, d});
      drive_frame(0, d, 1'b0, 1'b0, 1'b1, -1);
    end
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      flip = 1'($urandom_range(0, 1));
      exp_b_q.push_back({flip, 1'b0, d});
      drive_frame(1, d, 1'b1, (^d) ^ flip, 1'b1, -1);
    end
    idle(4);
    while (exp_a_q.size() > 0) begin
      exp = exp_a_q.pop_front();
      total++;
      if (rd_a >= wr_a) begin bad++; $display("FAIL b2b_a: got none want %h", exp); end
      else begin
        got = cap_a[rd_a[5:0]];
        rd_a++;
        if (got !== exp) begin bad++; $display("FAIL b2b_a: got %h want %h", got, exp); end
      end
    end
    while (exp_b_q.size() > 0) begin
      exp = exp_b_q.pop_front();
      total++;
      if (rd_b >= wr_b) begin bad++; $display("FAIL b2b_b: got none want %h", exp); end
      else begin
        got = cap_b[rd_b[5:0]];
        rd_b++;
        if (got !== exp) begin bad++; $display("FAIL b2b_b: got %h want %h", got, exp); end
      end
    end
    total++;
    if (wr_a != rd_a || wr_b != rd_b) begin
      bad++;
      $display("FAIL b2b_extra: got %0d/%0d extra want 0/0", wr_a - rd_a, wr_b - rd_b);
      rd_a = wr_a;
      rd_b = wr_b;
    end
  endtask

  task automatic test_overrun;
    logic [9:0] exp, got;
    int ov0;
    ov0 = ovr_a;
    @(posedge clk);
    #2 ready_a = 1'b0;
    exp_a_q.push_back({2'b00, 8'h11});
    drive_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
    drive_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    total += 3;
    if (valid_a !== 1'b1) begin bad++; $display("FAIL ovr_valid_held: got %b want 1", valid_a); end
    if (data_out_a !== 8'h11) begin bad++; $display("FAIL ovr_data_held: got %h want 11", data_out_a); end
    if (ovr_a - ov0 != 1) begin bad++; $display("FAIL ovr_pulse: got %0d cycles want 1", ovr_a - ov0); end
    @(posedge clk);
    #2 ready_a = 1'b1;
    idle(4);
    total++;
    if (valid_a !== 1'b0) begin bad++; $display("FAIL ovr_valid_drop: got %b want 0", valid_a); end
    while (exp_a_q.size() > 0) begin
      exp = exp_a_q.pop_front();
      total++;
      if (rd_a >= wr_a) begin bad++; $display("FAIL ovr_frame: got none want %h", exp); end
      else begin
        got = cap_a[rd_a[5:0]];
        rd_a++;
        if (got !== exp) begin bad++; $display("FAIL ovr_frame: got %h want %h", got, exp); end
      end
    end
    total++;
    if (wr_a != rd_a) begin bad++; $display("FAIL ovr_dropped_shown: got %0d extra want 0", wr_a - rd_a); rd_a = wr_a; end
  endtask

  task automatic test_mid_reset;
    logic [9:0] exp, got;
    @(posedge clk);
    #2 ready_a = 1'b0;
    drive_frame(0, 8'h33, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    total++;
    if (valid_a !== 1'b1) begin bad++; $display("FAIL mreset_pre_valid: got %b want 1", valid_a); end
    fork
      drive_frame(0, 8'h44, 1'b0, 1'b0, 1'b1, -1);
      begin
        idle(60);
        rst_n = 1'b0;
        #1;
        total += 6;
        if (valid_a !== 1'b0) begin bad++; $display("FAIL mreset_valid: got %b want 0", valid_a); end
        if (data_out_a !== 8'h00) begin bad++; $display("FAIL mreset_data: got %h want 00", data_out_a); end
        if (parity_err_a !== 1'b0) begin bad++; $display("FAIL mreset_perr: got %b want 0", parity_err_a); end
        if (frame_err_a !== 1'b0) begin bad++; $display("FAIL mreset_ferr: got %b want 0", frame_err_a); end
        if (overrun_a !== 1'b0) begin bad++; $display("FAIL mreset_overrun: got %b want 0", overrun_a); end
        if (state_a !== 3'd0) begin bad++; $display("FAIL mreset_state: got %0d want 0", state_a); end
      end
    join
    idle(3);
    rst_n = 1'b1;
    ready_a = 1'b1;
    idle(40);
    total++;
    if (wr_a != rd_a) begin bad++; $display("FAIL mreset_spurious: got %0d frames want 0", wr_a - rd_a); rd_a = wr_a; end
    exp_a_q.push_back({2'b00, 8'h96});
    drive_frame(0, 8'h96, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    while (exp_a_q.size() > 0) begin
      exp = exp_a_q.pop_front();
      total++;
      if (rd_a >= wr_a) begin bad++; $display("FAIL mreset_recover: got none want %h", exp); end
      else begin
        got = cap_a[rd_a[5:0]];
        rd_a++;
        if (got !== exp) begin bad++; $display("FAIL mreset_recover: got %h want %h", got, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_spike();
    test_back_to_back();
    test_overrun();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver in the receiver path. Adds configurable data width, parity and stop bits, and 3-sample majority voting at mid-bit. Adds false-start rejection, parity/framing/overrun error reporting, and a valid/ready output handshake. It sits between the board RX pin and the byte-consuming logic, such as the packet parser or FIFO.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line rate; BAUD_CNT = CLK_FREQ/BAUD clocks per bit, must be >= 8
DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  asynchronous serial line, idle high
data_out  output  DATA_BITS  received data word, stable while valid=1
valid  output  1  frame available; held until accepted
ready  input  1  consumer accept; transfer occurs when valid & ready on a clk edge
parity_err  output  1  parity mismatch for the word in data_out; meaningful only while valid=1
frame_err  output  1  at least one stop bit sampled 0 for the word in data_out; meaningful only while valid=1
overrun  output  1  one-cycle pulse: a frame completed while valid=1 and ready=0; that new frame is dropped

Behaviour:
- Reset (async, rst_n=0):
  - Sync flops = 1, FSM = IDLE, bit counter = 0.
  - data_out = 0, valid = 0, parity_err = 0, frame_err = 0, overrun = 0.
  - Reset mid-frame aborts the frame. Nothing is delivered.
- rx passes through a 2-flop synchroniser (reset to 1); rx_s is the output. All decisions use rx_s.
- Tick counter, width $clog2(BAUD_CNT), counts 0..BAUD_CNT-1 within each bit. H = BAUD_CNT/2.
  - Samples are taken at ticks H-1, H and H+1. The bit value is the majority of the 3 samples, decided at tick H+1.
  - The next bit begins after tick BAUD_CNT-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rx_s==0, go to START with tick=0. That cycle is tick 0 of the start bit.
  - START: at decision, majority 1 means a false start: return to IDLE with no outputs or flags. Majority 0 goes to DATA.
  - DATA: DATA_BITS bits, shifted LSB first into an internal register. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: at decision, compute the expected bit. Even parity: XOR of data. Odd parity: its inverse. Record a mismatch.
  - STOP: STOP_BITS bits. Any stop bit with majority 0 sets the internal frame error.
    - At the decision of the final stop bit the frame completes and the FSM returns to IDLE immediately, not waiting for the bit end. This gives a half-bit resync margin.
- Completion, at the decision cycle of the final stop bit:
  - If valid==0, or valid & ready in the same cycle: the next clock loads data_out, parity_err and frame_err, and sets valid=1.
  - Otherwise the frame is dropped, data_out is unchanged, and overrun pulses high for exactly one cycle.
- valid clears on the edge where valid & ready. A simultaneous completion wins, and valid stays 1 with the new word.
- Latency: valid rises 1 clk after the final stop-bit decision tick. This is 2 synchroniser clocks + (1 + DATA_BITS + P + S-1) * BAUD_CNT + H+1 + 1 clocks after the rx falling edge, where P = 1 if parity is enabled, else 0, and S = STOP_BITS.
- Frames with errors are still delivered, with the flags set.
- After a frame with frame_err=1, IDLE ignores rx_s==0 until rx_s==1 has been seen for one cycle. This prevents retriggering during a break.
- After reset, the same rx_s==1 qualification applies before the first start.

Test Plan:
- Config: CLK_FREQ=1_600_000, BAUD=100_000 (BAUD_CNT=16), 8N1, ready=1. Send 0xA5 -> valid for 1 cycle, data_out=0xA5, parity_err=0, frame_err=0.
- PARITY=1, send 0x03 with parity bit 1 (should be 0) -> data_out=0x03, parity_err=1. Then send 0x07 with parity 1 -> parity_err=0.
- Stop bit driven 0, then line held low 40 clks, then high, then a valid frame 0x5A:
  - First frame: frame_err=1.
  - No spurious frame during the low period.
  - Next frame: 0x5A delivered with clean flags.
- Idle line with a low glitch of 4 clks -> no valid, FSM back in IDLE. A later frame 0x3C is received correctly.
- Data bit 0x00 pattern with a 1-clk high spike at tick H of bit 2 -> majority rejects it, data_out=0x00.
- ready=0, two back-to-back frames 0x11 then 0x22 -> valid stays 1 with data_out=0x11, overrun pulses once.
  - Assert ready -> valid drops, and 0x22 is never presented.
  - Reset asserted mid-frame -> all outputs 0 immediately.
